// File: rtl/ex_stage_pkg.sv
// Shared constants for the MIPS execute stage: bus widths, ALU op/class codes
// and the divider state encoding.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;

  localparam logic [DATA_W-1:0]     ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring radix-2 divider. busy covers the accepting cycle and every
// working cycle; ready marks the single cycle in which result is valid.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                busy
);

  localparam int CNT_W = $clog2(DIV_STEPS) + 1;

  div_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] remquo;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quo;
  logic                neg_rem;
  logic [2*DATA_W-1:0] remquo_next;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic en);
    return (en && v < 0) ? -v : v;
  endfunction

  // The partial remainder can reach 33 bits after the shift when the divisor
  // is above 2^31, so the compare keeps the bit shifted out of the top.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [2*DATA_W-1:0] rq,
                                                   input logic [DATA_W-1:0]   d);
    logic [DATA_W:0]     top;
    logic [2*DATA_W-1:0] sh;
    top = rq[2*DATA_W-1:DATA_W-1];
    sh  = {rq[2*DATA_W-2:0], 1'b0};
    if (top >= {1'b0, d})
      return {top[DATA_W-1:0] - d, sh[DATA_W-1:1], 1'b1};
    return sh;
  endfunction

  function automatic logic [2*DATA_W-1:0] sign_fix(input logic [2*DATA_W-1:0] rq,
                                                   input logic nq, input logic nr);
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    q = rq[DATA_W-1:0];
    r = rq[2*DATA_W-1:DATA_W];
    return {nr ? -r : r, nq ? -q : q};
  endfunction

  assign remquo_next = div_step(remquo, divisor);
  assign ready       = (state == DIV_END);
  assign busy        = (state == DIV_FREE && start) || state == DIV_BYZERO || state == DIV_ON;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start) begin
            if (opdata2 == ZERO_WORD) begin
              state <= DIV_BYZERO;
            end else begin
              remquo  <= {ZERO_WORD, abs_val(opdata1, signed_div)};
              divisor <= abs_val(opdata2, signed_div);
              neg_quo <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              neg_rem <= signed_div && opdata1[DATA_W-1];
              cnt     <= '0;
              state   <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          result <= '0;
          state  <= DIV_END;
        end
        DIV_ON: begin
          remquo <= remquo_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_STEPS - 1)) begin
            result <= sign_fix(remquo_next, neg_quo, neg_rem);
            state  <= DIV_END;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU result mux plus the glue that turns the
// iterative divider into a pipeline stall and a one-cycle HI/LO write.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o
);

  logic signed [DATA_W-1:0] reg1_s;
  logic signed [DATA_W-1:0] reg2_s;
  logic [DATA_W-1:0]        logic_res;
  logic [DATA_W-1:0]        shift_res;
  logic [DATA_W-1:0]        arith_res;
  logic [2*DATA_W-1:0]      div_result;
  logic                     div_ready;
  logic                     div_busy;
  logic                     is_div;

  assign reg1_s = reg1_i;
  assign reg2_s = reg2_i;
  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  ex_div #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .result     (div_result),
    .ready      (div_ready),
    .busy       (div_busy)
  );

  always_comb begin
    logic_res = ZERO_WORD;
    shift_res = ZERO_WORD;
    arith_res = ZERO_WORD;
    case (aluop_i)
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  shift_res = reg2_s >>> reg1_i[4:0];
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, reg1_s < reg2_s};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
      default: ;
    endcase
  end

  // Divides write only HI/LO; the GPR write is suppressed for them.
  always_comb begin
    wd_o    = NOP_REG_ADDR;
    wreg_o  = 1'b0;
    wdata_o = ZERO_WORD;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i && !is_div;
      if (!is_div) begin
        case (alusel_i)
          EXE_RES_LOGIC: wdata_o = logic_res;
          EXE_RES_SHIFT: wdata_o = shift_res;
          EXE_RES_ARITH: wdata_o = arith_res;
          default:       wdata_o = ZERO_WORD;
        endcase
      end
    end
  end

  assign stallreq_o = !rst && div_busy;
  assign whilo_o    = !rst && div_ready;
  assign hi_o       = whilo_o ? div_result[2*DATA_W-1:DATA_W] : ZERO_WORD;
  assign lo_o       = whilo_o ? div_result[DATA_W-1:0] : ZERO_WORD;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU results, divider latency/results,
// divide-by-zero and reset abandoning a division in flight.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ALUOP_W-1:0]    aluop;
  logic [ALUSEL_W-1:0]   alusel;
  logic [DATA_W-1:0]     reg1;
  logic [DATA_W-1:0]     reg2;
  logic [REG_ADDR_W-1:0] wd;
  logic                  wreg;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [DATA_W-1:0]     wdata_o;
  logic                  whilo_o;
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;
  logic                  stallreq_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage #(.DIV_STEPS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [ALUOP_W-1:0] op, input logic [ALUSEL_W-1:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    aluop  = op;
    alusel = sel;
    reg1   = a;
    reg2   = b;
    #1;
  endtask

  // Presents a divide for the first stall cycle, scrambles operands on the
  // second cycle (they must already be latched), and checks the result cycle.
  task automatic run_div(input string tag, input logic [ALUOP_W-1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int nstall,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    tick();
    set_op(op, EXE_RES_NOP, a, b);
    chk({tag, "_wreg"}, wreg_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    for (int c = 1; c <= nstall; c++) begin
      if (c > 1) begin
        tick();
        if (c == 2) set_op(op, EXE_RES_NOP, 32'h1234_5678, 32'h0000_0003);
        else #1;
      end
      chk($sformatf("%s_stall_c%0d", tag, c), stallreq_o, 1);
      chk($sformatf("%s_whilo_c%0d", tag, c), whilo_o, 0);
    end
    tick();
    #1;
    chk({tag, "_whilo"}, whilo_o, 1);
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_stall_end"}, stallreq_o, 0);
    set_op(EXE_NOP_OP, EXE_RES_NOP, 0, 0);
    tick();
    #1;
    chk({tag, "_whilo_after"}, whilo_o, 0);
    chk({tag, "_lo_after"}, lo_o, 0);
    chk({tag, "_stall_after"}, stallreq_o, 0);
  endtask

  initial begin
    logic saw_whilo;
    rst  = 1'b1;
    wd   = 5'd5;
    wreg = 1'b1;
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000);
    tick();
    tick();
    #1;
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_whilo", whilo_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    chk("rst_stall_div", stallreq_o, 0);

    tick();
    rst = 1'b0;
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000);
    chk("or_wdata", wdata_o, 32'h0F0F_F0F0);
    chk("or_wd", wd_o, 5);
    chk("or_wreg", wreg_o, 1);
    chk("or_stall", stallreq_o, 0);
    chk("or_whilo", whilo_o, 0);

    tick(); set_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
    chk("sra", wdata_o, 32'hF800_0000);
    tick(); set_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
    chk("srl", wdata_o, 32'h0800_0000);
    tick(); set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd8, 32'h0000_0001);
    chk("sll", wdata_o, 32'h0000_0100);
    tick(); set_op(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
    chk("slt", wdata_o, 32'd1);
    tick(); set_op(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", wdata_o, 32'd0);
    tick(); set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd2);
    chk("addu_wrap", wdata_o, 32'd1);
    tick(); set_op(EXE_SUBU_OP, EXE_RES_ARITH, 32'd0, 32'd1);
    chk("subu_wrap", wdata_o, 32'hFFFF_FFFF);
    tick(); set_op(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00FF, 32'hFF00_0000);
    chk("nor", wdata_o, 32'h00FF_FF00);
    tick(); set_op(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF);
    chk("and", wdata_o, 32'h00F0_1234);
    tick(); set_op(EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_0000, 32'hFFFF_0001);
    chk("xor", wdata_o, 32'h5555_0001);
    tick(); set_op(EXE_OR_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd1);
    chk("alusel_nop", wdata_o, 0);

    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_by0", EXE_DIV_OP, 32'd55, 32'd0, 2, 32'd0, 32'd0);
    run_div("divu_big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'd1, 32'h7FFF_FFFE);

    // Abandon a DIVU at step 10 with reset.
    tick();
    set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
    chk("abort_stall_start", stallreq_o, 1);
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 0, 0);
    chk("abort_stall_in_rst", stallreq_o, 0);
    tick();
    #1;
    chk("abort_stall_next", stallreq_o, 0);
    chk("abort_whilo_next", whilo_o, 0);
    tick();
    rst = 1'b0;
    saw_whilo = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) saw_whilo = 1'b1;
      tick();
    end
    chk("abort_no_hilo_write", saw_whilo, 0);
    run_div("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its ex_* outputs.
- Computes logic, shift and integer arithmetic results in one cycle.
- Contains an iterative 32-step radix-2 divider for DIV/DIVU. Holds the pipeline with a stall request until the quotient and remainder are ready.
- Result bundle goes to the EX/MEM register; HI/LO write requests go to the HI/LO file.

Parameters:
- DIV_STEPS, 32, divider iterations; equals data width; fixed for MIPS32.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset (`RstEnable = 1'b1)
- aluop_i  in  `AluOpBus  operation subtype from ID/EX
- alusel_i  in  `AluSelBus  result class from ID/EX
- reg1_i  in  `RegBus  source operand 1
- reg2_i  in  `RegBus  source operand 2
- wd_i  in  `RegAddrBus  destination register address
- wreg_i  in  1  destination write enable
- wd_o  out  `RegAddrBus  destination address to EX/MEM
- wreg_o  out  1  write enable to EX/MEM
- wdata_o  out  `RegBus  GPR result
- whilo_o  out  1  HI/LO write strobe
- hi_o  out  `RegBus  HI write data (remainder)
- lo_o  out  `RegBus  LO write data (quotient)
- stallreq_o  out  1  request stall of PC, IF/ID and ID/EX

Behaviour:
- Reset state while rst=1:
  - Divider FSM goes to DIV_FREE.
  - All outputs are forced to 0: wreg_o=`WriteDisable, wd_o=`NOPRegAddr, stallreq_o=0, whilo_o=0.
- Reset has priority over every other event, including mid-division. The division is abandoned and no HI/LO write occurs.
- ALU datapath (combinational, 0-cycle latency from inputs):
  - Logic: AND, OR, XOR, NOR on reg1_i and reg2_i.
  - Shift: SLL, SRL, SRA shift reg2_i by reg1_i[4:0]. SRA replicates reg2_i[31].
  - Arithmetic: ADDU and SUBU wrap modulo 2^32 with no overflow trap. SLT is a signed compare; SLTU is unsigned. Both give 32'd1 or 32'd0.
  - wdata_o is selected by alusel_i (LOGIC, SHIFT or ARITH). Any other alusel_i value, including NOP, gives 0.
  - wd_o=wd_i; wreg_o=wreg_i.
- DIV/DIVU: wreg_o=0 and wdata_o=0 (results go to HI/LO only).
- Divider FSM states are DIV_FREE, DIV_BYZERO, DIV_ON and DIV_END.
  - FREE + DIV/DIVU with reg2_i≠0:
    - Latch the operands. For DIV, latch absolute values plus sign flags.
    - Clear the step counter and go to ON.
    - stallreq_o=1 this cycle.
  - FREE + DIV/DIVU with reg2_i=0: go to BYZERO; stallreq_o=1.
  - BYZERO: quotient=0 and remainder=0; go to END; stallreq_o=1.
  - ON, once per cycle:
    - Shift the {rem,quo} register left by 1.
    - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
    - Increment the counter.
    - After step 32, go to END. stallreq_o=1 throughout.
  - END:
    - For DIV, negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
    - lo_o=quotient, hi_o=remainder, whilo_o=1 for exactly this cycle, stallreq_o=0. Go to FREE.
- Latency: a non-zero divide asserts stallreq_o for 33 cycles (FREE + 32 ON). The result appears on the 34th cycle.
  - Divide-by-zero stalls for 2 cycles; the result appears on the 3rd.
- Operands are latched at start. Input changes during ON or BYZERO are ignored.
- A new divide in the ID/EX register on the cycle after END is accepted as a fresh operation, because the stall released at END.
- Non-divide ops: whilo_o=0, hi_o=0, lo_o=0.
- Integration requirement: ID/EX and the upstream stages must hold their contents while stallreq_o=1. That stall input is delivered by the pipeline controller.

Decomposition:
- Shared `include "defines.v" holds the following constants:
  - aluop codes: EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP.
  - alusel codes: EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_NOP.
  - Divider state encodings: DivFree, DivByZero, DivOn, DivEnd.
  - Bus widths and ZeroWord.
- One sub-module, ex_div: FSM, counter, shift/subtract datapath and sign fix-up.
  - Interface: start, signed_div, opdata1, opdata2 in; result[63:0], ready, busy out.
- ex_stage keeps the ALU mux and the stall/HI-LO glue.

Test Plan:
- OR reg1=0x0000_F0F0, reg2=0x0F0F_0000, wd=5, wreg=1 -> same cycle: wdata_o=0x0F0F_F0F0, wd_o=5, wreg_o=1, stallreq_o=0.
- SRA reg1=4, reg2=0x8000_0000 -> wdata_o=0xF800_0000. SLT reg1=0xFFFF_FFFF, reg2=1 -> 1. SLTU with the same operands -> 0.
- DIVU reg1=100, reg2=7, held -> stallreq_o=1 for 33 cycles. Cycle 34: whilo_o=1, lo_o=14, hi_o=2, stallreq_o=0. Cycle 35: whilo_o=0.
- DIV reg1=-7 (0xFFFF_FFF9), reg2=2 -> lo_o=0xFFFF_FFFD (-3), hi_o=0xFFFF_FFFF (-1).
- DIV reg2=0 -> stallreq_o=1 for 2 cycles, then whilo_o=1 with hi_o=0 and lo_o=0.
- DIVU started, then rst=1 at step 10 -> next cycle stallreq_o=0. After rst drops, whilo_o never pulses for the abandoned op. A new DIVU 9/3 then gives lo_o=3, hi_o=0.
